// File: rtl/fetch_cycle.sv
// IF stage: owns the PC, fetches over req/gnt/rvalid and feeds the IF/ID register.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_cycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic        valid_D,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_bubble_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] buf_q, buf_d;
    logic        discard_q, discard_d;
    logic [31:0] instr_q, pc_d_q;
    logic        valid_q;

    logic        deliver;
    logic [31:0] deliver_instr;
    logic        load_bubble;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        buf_d         = buf_q;
        discard_d     = discard_q;
        deliver       = 1'b0;
        deliver_instr = buf_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect_i) begin
                    pc_d = redirect_tgt;
                    if (imem_gnt_i) begin
                        state_d   = S_WAIT;
                        req_pc_d  = pc_q;
                        discard_d = 1'b1;
                    end
                end else if (imem_gnt_i) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    pc_d = redirect_tgt;
                    if (imem_rvalid_i) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else if (!stall_i) begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata_i;
                        pc_d          = req_pc_q + 32'd4;
                        state_d       = S_REQ;
                    end else begin
                        buf_d   = imem_rdata_i;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (!stall_i) begin
                    deliver = 1'b1;
                    pc_d    = req_pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Redirect forces a bubble even while stalled.
    assign load_bubble = redirect_i || (!stall_i && !deliver);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= RESET_PC;
            buf_q     <= NOP_INSTR;
            discard_q <= 1'b0;
            instr_q   <= NOP_INSTR;
            pc_d_q    <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            buf_q     <= buf_d;
            discard_q <= discard_d;
            if (load_bubble) begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end else if (deliver) begin
                instr_q <= deliver_instr;
                pc_d_q  <= req_pc_q;
                valid_q <= 1'b1;
            end
        end
    end

    assign imem_req_o  = (state_q == S_REQ);
    assign imem_addr_o = {pc_q[31:2], 2'b00};
    assign instr_D     = instr_q;
    assign pc_D        = pc_d_q;
    assign valid_D     = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, bubble_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetched_q <= 32'd0;
            bubble_q  <= 32'd0;
        end else begin
            if (load_bubble)
                bubble_q <= bubble_q + 32'd1;
            else if (deliver)
                fetched_q <= fetched_q + 32'd1;
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_bubble_o  = bubble_q;
`else
    assign perf_fetched_o = 32'd0;
    assign perf_bubble_o  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed bench for fetch_cycle: handshake, stall/hold, redirect and wrap cases.
// Counter expectations follow FETCH_PERF_CNT_EN when it is defined.
module tb_fetch_cycle;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic        valid_D;
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_bubble_o;

    int n_cmp = 0;
    int n_err = 0;

    fetch_cycle dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .instr_D        (instr_D),
        .pc_D           (pc_D),
        .valid_D        (valid_D),
        .perf_fetched_o (perf_fetched_o),
        .perf_bubble_o  (perf_bubble_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        step();
        step();
        check("rst_req", {31'd0, imem_req_o}, 32'd1);
        check("rst_addr", imem_addr_o, 32'd0);
        check("rst_instr", instr_D, NOP);
        check("rst_pc", pc_D, 32'd0);
        check("rst_valid", {31'd0, valid_D}, 32'd0);
        check("rst_pf", perf_fetched_o, 32'd0);

        // first fetch at 0x0
        rst_i      = 1'b0;
        imem_gnt_i = 1'b1;
        step();
        check("f0_wait_req", {31'd0, imem_req_o}, 32'd0);
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0050_0093;
        step();
        check("f0_instr", instr_D, 32'h0050_0093);
        check("f0_pc", pc_D, 32'd0);
        check("f0_valid", {31'd0, valid_D}, 32'd1);
        check("f0_next", imem_addr_o, 32'h4);
        imem_rvalid_i = 1'b0;

        // stall across the rvalid cycle
        imem_gnt_i = 1'b1;
        step();
        check("f1_bubble", {31'd0, valid_D}, 32'd0);
        imem_gnt_i    = 1'b0;
        stall_i       = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h00a0_0113;
        step();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        step();
        step();
        check("hold_req", {31'd0, imem_req_o}, 32'd0);
        check("hold_instr", instr_D, NOP);
        check("hold_valid", {31'd0, valid_D}, 32'd0);
        stall_i = 1'b0;
        step();
        check("hold_rel_instr", instr_D, 32'h00a0_0113);
        check("hold_rel_pc", pc_D, 32'h4);
        check("hold_rel_valid", {31'd0, valid_D}, 32'd1);
        check("hold_rel_addr", imem_addr_o, 32'h8);

        // redirect while waiting on 0x8
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        check("rd_wait_req", {31'd0, imem_req_o}, 32'd0);
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hdead_beef;
        step();
        check("rd_drop_instr", instr_D, NOP);
        check("rd_drop_valid", {31'd0, valid_D}, 32'd0);
        check("rd_addr", imem_addr_o, 32'h100);
        check("rd_req", {31'd0, imem_req_o}, 32'd1);
        imem_rvalid_i = 1'b0;
        imem_gnt_i    = 1'b1;
        step();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0010_0193;
        step();
        check("rd_new_instr", instr_D, 32'h0010_0193);
        check("rd_new_pc", pc_D, 32'h100);
        check("rd_new_addr", imem_addr_o, 32'h104);
        imem_rvalid_i = 1'b0;

        // redirect + rvalid + stall on one edge; target misaligned
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h1111_1111;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h203;
        stall_i       = 1'b1;
        step();
        check("rs_instr", instr_D, NOP);
        check("rs_valid", {31'd0, valid_D}, 32'd0);
        check("rs_pc", pc_D, 32'h100);
        check("rs_addr", imem_addr_o, 32'h200);
        check("rs_req", {31'd0, imem_req_o}, 32'd1);
        imem_rvalid_i = 1'b0;
        stall_i       = 1'b0;

        // redirect in REQ without gnt, then wrap past 0xFFFFFFFC
        redirect_pc_i = 32'hffff_fffe;
        step();
        check("wr_addr", imem_addr_o, 32'hffff_fffc);
        redirect_i = 1'b0;
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0000_0033;
        step();
        check("wr_instr", instr_D, 32'h0000_0033);
        check("wr_pc", pc_D, 32'hffff_fffc);
        check("wr_next", imem_addr_o, 32'h0);
        imem_rvalid_i = 1'b0;

        // redirect with gnt in REQ: stale response must be discarded
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        imem_gnt_i    = 1'b1;
        step();
        check("rg_req", {31'd0, imem_req_o}, 32'd0);
        redirect_i    = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h2222_2222;
        step();
        check("rg_valid", {31'd0, valid_D}, 32'd0);
        check("rg_addr", imem_addr_o, 32'h40);
        check("rg_req2", {31'd0, imem_req_o}, 32'd1);

        // rvalid seen in REQ is ignored
        step();
        check("ign_req", {31'd0, imem_req_o}, 32'd1);
        check("ign_valid", {31'd0, valid_D}, 32'd0);
        check("ign_addr", imem_addr_o, 32'h40);
        imem_rvalid_i = 1'b0;

`ifdef FETCH_PERF_CNT_EN
        check("pf_fetched", perf_fetched_o, 32'd4);
        check("pf_bubble_ge2", {31'd0, (perf_bubble_o >= 32'd2)}, 32'd1);
`else
        check("pf_fetched", perf_fetched_o, 32'd0);
        check("pf_bubble", perf_bubble_o, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_cycle.md
Name: fetch_cycle

Overview:
IF stage of the 5-stage RV32I pipeline; sits directly upstream of the decode stage and drives its instr_D / pc_D inputs through the IF/ID pipeline register.
- Owns the PC, issues requests to instruction memory over a req/gnt/rvalid handshake with at most one request outstanding.
- Honours hazard-unit stall and execute-stage redirect (taken branch/jump).
- Inserts NOP bubbles when no instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, encoding used for bubbles (ADDI x0,x0,0).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous reset, active-high.
stall_i  in  1  hazard unit: hold IF/ID register and PC.
redirect_i  in  1  execute stage: taken branch/jump, flush IF/ID.
redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced 0).
imem_req_o  out  1  instruction fetch request.
imem_addr_o  out  32  fetch address, word aligned.
imem_gnt_i  in  1  request accepted this cycle.
imem_rvalid_i  in  1  response valid, at least 1 cycle after gnt.
imem_rdata_i  in  32  response instruction.
instr_D  out  32  IF/ID instruction to decode.
pc_D  out  32  IF/ID PC to decode.
valid_D  out  1  1 = real instruction, 0 = bubble.
perf_fetched_o  out  32  optional counter (see Optional Feature).
perf_bubble_o  out  32  optional counter.

Behaviour:
- Reset (rst_i=1 at clock edge): pc_F=RESET_PC, state=REQ, discard=0, instr_D=NOP_INSTR, pc_D=0, valid_D=0, buffer cleared. Outputs combinationally: imem_req_o=1 in REQ only, imem_addr_o=pc_F.
- Reset mid-operation aborts any outstanding request. An rvalid seen in REQ state is always ignored.
- FSM states:
  - REQ: imem_req_o=1. gnt -> WAIT; latch req_pc=pc_F.
  - WAIT: await rvalid. If discard=1: drop data, clear discard, go to REQ. Else if stall_i=0: IF/ID <= {rdata, req_pc, valid=1}, pc_F <= req_pc+4 (wraps mod 2^32), go to REQ. Else (stall_i=1): store rdata in buffer, go to HOLD.
  - HOLD: when stall_i=0, IF/ID <= buffer with valid=1, pc_F <= req_pc+4, go to REQ.
- IF/ID update rule when no instruction is delivered and stall_i=0: load bubble {NOP_INSTR, pc_D unchanged, valid=0}. When stall_i=1, IF/ID holds its value.
- Best-case throughput: 1 instruction per 2 cycles (gnt cycle + rvalid cycle). Latency from gnt to IF/ID = rvalid cycle + 1 edge.
- Redirect has the highest priority and overrides stall_i on the same edge:
  - pc_F <= {redirect_pc_i[31:2],2'b00}; IF/ID <= bubble; buffer dropped.
  - REQ with gnt the same cycle: go to WAIT with discard=1 (request went out with the old PC).
  - REQ without gnt: stay in REQ; the new address is driven next cycle.
  - WAIT with rvalid the same cycle: drop data, go to REQ.
  - WAIT without rvalid: set discard=1, stay in WAIT.
  - HOLD: go to REQ.
- Back-to-back redirects: the latest target wins. discard stays 1 until one response is consumed; it never counts above one.
- imem_addr_o is never misaligned. pc_F is never incremented by a discarded response.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: perf_fetched_o increments on each IF/ID load with valid=1. perf_bubble_o increments on each IF/ID bubble load. Both counters are 32-bit, wrap at 2^32, reset to 0, and do not count while stall_i holds IF/ID.
- Undefined: both ports are present and tied to 32'd0; no counter flops are synthesised.

Test Plan:
- Reset release, memory responds 1 cycle after gnt with 0x00500093 at 0x0 -> imem_addr_o=0x0, then instr_D=0x00500093, pc_D=0x0, valid_D=1; next request at 0x4.
- stall_i=1 across the rvalid cycle for 3 cycles -> IF/ID holds its old value, FSM in HOLD; one edge after stall_i falls, instr_D = the buffered word, valid_D=1, imem_addr_o advances by 4.
- Redirect to 0x100 while in WAIT for 0x8 -> the 0x8 response is dropped, valid_D=0, next imem_addr_o=0x100, pc_D=0x100 after its response.
- Redirect and rvalid in the same cycle, with stall_i=1 -> data dropped, IF/ID=bubble (NOP_INSTR, valid_D=0) despite the stall.
- redirect_pc_i=0x203 -> imem_addr_o=0x200. pc_F=0xFFFFFFFC fetched -> next address 0x0.
- With FETCH_PERF_CNT_EN, 4 valid fetches and 2 redirects -> perf_fetched_o=4, perf_bubble_o >= 2. Without the macro both read 0.
